// File: rtl/multicycle_computer.sv
// Multicycle accumulator core. A FETCH/EXEC/MEM/HALT sequencer drives the A/B registers,
// the Z/C flags, a bounded return-address stack and a request/acknowledge data-memory port.
module multicycle_computer #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [DATA_W+6:0] imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] regA_out,
  output logic [DATA_W-1:0] regB_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              halted,
  output logic              fault
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  localparam logic [6:0] OP_LDA  = 7'h01, OP_LDB  = 7'h02, OP_MOVAB = 7'h03, OP_MOVBA = 7'h04;
  localparam logic [6:0] OP_ADD  = 7'h05, OP_SUB  = 7'h06, OP_AND   = 7'h07, OP_OR    = 7'h08;
  localparam logic [6:0] OP_XOR  = 7'h09, OP_ADDI = 7'h0A, OP_SUBI  = 7'h0B, OP_CMP   = 7'h0C;
  localparam logic [6:0] OP_CMPI = 7'h0D, OP_LDL  = 7'h10, OP_LDR   = 7'h11, OP_STL   = 7'h12;
  localparam logic [6:0] OP_STR  = 7'h13, OP_JMP  = 7'h20, OP_JEQ   = 7'h21, OP_JNE   = 7'h22;
  localparam logic [6:0] OP_JLT  = 7'h23, OP_JGE  = 7'h24, OP_CALL  = 7'h28, OP_RET   = 7'h29;
  localparam logic [6:0] OP_HALT = 7'h7F;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W+6:0]   ir_q, ir_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                z_q, z_d, c_q, c_d;
  logic                fault_q, fault_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [PC_W-1:0]     stack_q [STACK_DEPTH];
  logic [PC_W-1:0]     stack_d [STACK_DEPTH];

  logic [6:0]          op;
  logic [DATA_W-1:0]   lit;
  logic [PC_W-1:0]     pcInc;
  logic [PC_W-1:0]     stackTop;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W-1:0]   logicRes;
  logic                borrow;
  logic                memWr;

  assign op       = ir_q[DATA_W+6:DATA_W];
  assign lit      = ir_q[DATA_W-1:0];
  assign pcInc    = pc_q + PC_W'(1);
  assign operand  = (op == OP_ADDI || op == OP_SUBI || op == OP_CMPI) ? lit : b_q;
  assign sum      = {1'b0, a_q} + {1'b0, operand};
  assign diff     = a_q - operand;
  assign borrow   = (a_q < operand);
  assign memWr    = (op == OP_STL || op == OP_STR);

  // The N flag is not kept: no instruction ever reads it.
  always_comb begin
    stackTop = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) stackTop = stack_q[i];
    end
    logicRes = '0;
    case (op)
      OP_AND:  logicRes = a_q & b_q;
      OP_OR:   logicRes = a_q | b_q;
      OP_XOR:  logicRes = a_q ^ b_q;
      default: logicRes = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    a_d        = a_q;
    b_d        = b_q;
    z_d        = z_q;
    c_d        = c_q;
    fault_d    = fault_q;
    sp_d       = sp_q;
    stack_d    = stack_q;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    unique case (state_q)
      FETCH: begin
        ir_d    = imem_data;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pcInc;
        case (op)
          OP_LDA:   a_d = lit;
          OP_LDB:   b_d = lit;
          OP_MOVAB: a_d = b_q;
          OP_MOVBA: b_d = a_q;
          OP_ADD, OP_ADDI: begin
            a_d = sum[DATA_W-1:0];
            c_d = sum[DATA_W];
            z_d = (sum[DATA_W-1:0] == '0);
          end
          OP_SUB, OP_SUBI: begin
            a_d = diff;
            c_d = borrow;
            z_d = (diff == '0);
          end
          OP_CMP, OP_CMPI: begin
            c_d = borrow;
            z_d = (diff == '0);
          end
          OP_AND, OP_OR, OP_XOR: begin
            a_d = logicRes;
            c_d = 1'b0;
            z_d = (logicRes == '0);
          end
          OP_LDL, OP_LDR, OP_STL, OP_STR: begin
            state_d = MEM;
            pc_d    = pc_q;
          end
          OP_JMP: pc_d = lit[PC_W-1:0];
          OP_JEQ: if (z_q)  pc_d = lit[PC_W-1:0];
          OP_JNE: if (!z_q) pc_d = lit[PC_W-1:0];
          OP_JLT: if (c_q)  pc_d = lit[PC_W-1:0];
          OP_JGE: if (!c_q) pc_d = lit[PC_W-1:0];
          OP_CALL: begin
            if (sp_q == SP_W'(STACK_DEPTH)) begin
              fault_d = 1'b1;
              state_d = HALT;
              pc_d    = pc_q;
            end else begin
              for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_q == SP_W'(i)) stack_d[i] = pcInc;
              end
              sp_d = sp_q + SP_W'(1);
              pc_d = lit[PC_W-1:0];
            end
          end
          OP_RET: begin
            if (sp_q == '0) begin
              fault_d = 1'b1;
              state_d = HALT;
              pc_d    = pc_q;
            end else begin
              sp_d = sp_q - SP_W'(1);
              pc_d = stackTop;
            end
          end
          OP_HALT: begin
            state_d = HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      // The request stays asserted with constant address/data until the acknowledge edge.
      MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = memWr;
        dmem_addr  = (op == OP_LDL || op == OP_STL) ? lit : b_q;
        dmem_wdata = a_q;
        if (dmem_ack) begin
          if (!memWr) a_d = dmem_rdata;
          pc_d    = pcInc;
          state_d = FETCH;
        end
      end
      HALT: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      fault_q <= 1'b0;
      sp_q    <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      c_q     <= c_d;
      fault_q <= fault_d;
      sp_q    <= sp_d;
      stack_q <= stack_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign regA_out  = a_q;
  assign regB_out  = b_q;
  assign halted    = (state_q == HALT);
  assign fault     = fault_q;

endmodule

// File: tb/tb_multicycle_computer.sv
// Bench for multicycle_computer: a table of single-instruction programs, directed timing
// sequences, and random straight-line programs checked against an instruction-level model.
`timescale 1ns/1ps
module tb_multicycle_computer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic [7:0]  imemAddr;
  logic [14:0] imemData;
  logic        dmemReq, dmemWe, dmemAck;
  logic [7:0]  dmemAddr, dmemWdata, dmemRdata;
  logic [7:0]  regA, regB, pcOut;
  logic        halted, fault;

  logic [3:0]  imemAddr2, pcOut2;
  logic [14:0] imemData2;
  logic        dmemReq2, dmemWe2;
  logic [7:0]  dmemAddr2, dmemWdata2, regA2, regB2;
  logic        halted2, fault2;

  logic [14:0] prog  [256];
  logic [14:0] prog2 [16];
  logic [7:0]  dmemArr [256];
  int          modelMem [256];

  assign imemData  = prog[imemAddr];
  assign imemData2 = prog2[imemAddr2];

  multicycle_computer #(.DATA_W(8), .PC_W(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imemAddr), .imem_data(imemData),
    .dmem_req(dmemReq), .dmem_we(dmemWe), .dmem_addr(dmemAddr), .dmem_wdata(dmemWdata),
    .dmem_rdata(dmemRdata), .dmem_ack(dmemAck), .regA_out(regA), .regB_out(regB),
    .pc_out(pcOut), .halted(halted), .fault(fault)
  );

  multicycle_computer #(.DATA_W(8), .PC_W(4), .STACK_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .imem_addr(imemAddr2), .imem_data(imemData2),
    .dmem_req(dmemReq2), .dmem_we(dmemWe2), .dmem_addr(dmemAddr2), .dmem_wdata(dmemWdata2),
    .dmem_rdata(8'h00), .dmem_ack(1'b0), .regA_out(regA2), .regB_out(regB2),
    .pc_out(pcOut2), .halted(halted2), .fault(fault2)
  );

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct { logic [7:0] addr; logic we; logic [7:0] wdata; } txn_t;
  typedef struct { logic [7:0] addr; logic we; logic [7:0] wdata; int cycles; bit stable; } log_t;
  txn_t expQ[$];
  log_t logQ[$];
  bit   respEnable = 1'b0;
  bit   randLat = 1'b0;
  bit   checkTxn = 1'b0;
  bit   forceAck = 1'b0;
  int   fixedLat = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [14:0] ins(input logic [6:0] op, input logic [7:0] lit);
    return {op, lit};
  endfunction

  // Data-memory responder: acknowledges after a chosen latency and logs each transaction.
  initial begin : responder
    bit   inTxn;
    int   cnt, cycles;
    bit   stable;
    txn_t cur, e;
    log_t lg;
    inTxn = 1'b0; cnt = 0; cycles = 0; stable = 1'b1;
    dmemAck = 1'b0; dmemRdata = 8'h00;
    forever begin
      @(negedge clk);
      dmemAck = forceAck;
      if (forceAck) dmemRdata = 8'hEE;
      if (!dmemReq) inTxn = 1'b0;
      else if (respEnable) begin
        if (!inTxn) begin
          inTxn = 1'b1;
          cur.addr = dmemAddr; cur.we = dmemWe; cur.wdata = dmemWdata;
          cycles = 0; stable = 1'b1;
          cnt = randLat ? int'($urandom_range(3, 0)) : fixedLat;
          if (checkTxn) begin
            if (expQ.size() == 0) begin
              nCompared++; nMismatched++;
              $display("[TB] FAIL txnUnexpected: got request addr 0x%0h, expected none", cur.addr);
            end else begin
              e = expQ.pop_front();
              checkOutput("txnAddr", cur.addr, e.addr);
              checkOutput("txnWe", cur.we, e.we);
              checkOutput("txnWdata", cur.wdata, e.wdata);
            end
          end
        end
        cycles++;
        if (dmemAddr !== cur.addr || dmemWe !== cur.we || dmemWdata !== cur.wdata) stable = 1'b0;
        if (cnt == 0) begin
          dmemAck = 1'b1;
          dmemRdata = dmemArr[cur.addr];
          if (cur.we) dmemArr[cur.addr] = cur.wdata;
          lg.addr = cur.addr; lg.we = cur.we; lg.wdata = cur.wdata;
          lg.cycles = cycles; lg.stable = stable;
          logQ.push_back(lg);
          inTxn = 1'b0;
        end else cnt--;
      end
    end
  end

  task automatic clearProg();
    for (int i = 0; i < 256; i++) prog[i] = ins(7'h7F, 8'h00);
  endtask

  task automatic clearProg2();
    for (int i = 0; i < 16; i++) prog2[i] = ins(7'h7F, 8'h00);
  endtask

  task automatic applyStimulus();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic reset2();
    rst2_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst2_n = 1'b1;
  endtask

  task automatic waitHalt(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin @(negedge clk); n++; end
    checkOutput({name, "_haltTimeout"}, halted, 1);
  endtask

  task automatic waitHalt2(input string name, input int budget);
    int n = 0;
    while (!halted2 && n < budget) begin @(negedge clk); n++; end
    checkOutput({name, "_haltTimeout"}, halted2, 1);
  endtask

  // Instruction-level reference: executes prog from address 0 over integer state.
  task automatic runModel(output int mA, output int mB, output int mPc, output bit mFault, output bit mHalt);
    int a, b, pc, op, lit, opnd, r, nextPc, steps;
    bit z, c;
    int stk[$];
    logic [14:0] w;
    txn_t t;
    a = 0; b = 0; pc = 0; z = 0; c = 0; mFault = 0; mHalt = 0; steps = 0;
    for (int i = 0; i < 256; i++) modelMem[i] = int'(dmemArr[i]);
    while (!mHalt && steps < 1000) begin
      steps++;
      w = prog[pc];
      op = int'(w[14:8]);
      lit = int'(w[7:0]);
      nextPc = (pc + 1) % 256;
      case (op)
        'h01: a = lit;
        'h02: b = lit;
        'h03: a = b;
        'h04: b = a;
        'h05, 'h0A: begin
          opnd = (op == 'h05) ? b : lit;
          r = a + opnd; c = (r > 255); a = r % 256; z = (a == 0);
        end
        'h06, 'h0B, 'h0C, 'h0D: begin
          opnd = (op == 'h06 || op == 'h0C) ? b : lit;
          c = (a < opnd); r = (a - opnd + 256) % 256; z = (r == 0);
          if (op < 'h0C) a = r;
        end
        'h07: begin a = a & b; c = 0; z = (a == 0); end
        'h08: begin a = a | b; c = 0; z = (a == 0); end
        'h09: begin a = a ^ b; c = 0; z = (a == 0); end
        'h10, 'h11, 'h12, 'h13: begin
          t.addr = 8'((op == 'h10 || op == 'h12) ? lit : b);
          t.we = (op >= 'h12);
          t.wdata = 8'(a);
          expQ.push_back(t);
          if (t.we) modelMem[t.addr] = a;
          else a = modelMem[t.addr];
        end
        'h20: nextPc = lit;
        'h21: if (z) nextPc = lit;
        'h22: if (!z) nextPc = lit;
        'h23: if (c) nextPc = lit;
        'h24: if (!c) nextPc = lit;
        'h28: begin
          if (stk.size() == 4) begin mFault = 1; mHalt = 1; end
          else begin stk.push_back(nextPc); nextPc = lit; end
        end
        'h29: begin
          if (stk.size() == 0) begin mFault = 1; mHalt = 1; end
          else nextPc = stk.pop_back();
        end
        'h7F: mHalt = 1;
        default: ;
      endcase
      if (!mHalt) pc = nextPc;
    end
    mA = a; mB = b; mPc = pc;
  endtask

  typedef struct {
    logic [6:0] op;
    logic [7:0] a, b, lit;
    logic [7:0] expA, expB, expPc;
  } vec_t;

  initial begin : main
    vec_t vecs[16];
    int   mA, mB, mPc, diffs, n;
    bit   mFault, mHalt;
    int   unk[5];
    int   r, op, t;

    unk = '{'h0E, 'h0F, 'h1F, 'h30, 'h7E};
    // Final PC encodes flags after the instruction under test: 06 C0Z0, 10 C0Z1, 21 C1Z0, 30 C1Z1.
    vecs[0]  = '{7'h05, 8'h80, 8'h80, 8'h00, 8'h00, 8'h80, 8'h30};
    vecs[1]  = '{7'h05, 8'h12, 8'h34, 8'h00, 8'h46, 8'h34, 8'h06};
    vecs[2]  = '{7'h06, 8'h10, 8'h20, 8'h00, 8'hF0, 8'h20, 8'h21};
    vecs[3]  = '{7'h06, 8'h20, 8'h20, 8'h00, 8'h00, 8'h20, 8'h10};
    vecs[4]  = '{7'h07, 8'hF0, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h10};
    vecs[5]  = '{7'h08, 8'hF0, 8'h0F, 8'h00, 8'hFF, 8'h0F, 8'h06};
    vecs[6]  = '{7'h09, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'hAA, 8'h10};
    vecs[7]  = '{7'h0A, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h30};
    vecs[8]  = '{7'h0B, 8'h05, 8'h00, 8'h06, 8'hFF, 8'h00, 8'h21};
    vecs[9]  = '{7'h0C, 8'h07, 8'h07, 8'h00, 8'h07, 8'h07, 8'h10};
    vecs[10] = '{7'h0D, 8'h03, 8'h00, 8'h04, 8'h03, 8'h00, 8'h21};
    vecs[11] = '{7'h03, 8'h11, 8'h22, 8'h00, 8'h22, 8'h22, 8'h21};
    vecs[12] = '{7'h04, 8'h11, 8'h22, 8'h00, 8'h11, 8'h11, 8'h21};
    vecs[13] = '{7'h00, 8'h11, 8'h22, 8'h00, 8'h11, 8'h22, 8'h21};
    vecs[14] = '{7'h0E, 8'h11, 8'h22, 8'h00, 8'h11, 8'h22, 8'h21};
    vecs[15] = '{7'h0A, 8'h05, 8'h00, 8'hFC, 8'h01, 8'h00, 8'h21};

    rst_n = 1'b0; rst2_n = 1'b0;
    clearProg(); clearProg2();
    for (int i = 0; i < 256; i++) dmemArr[i] = 8'h00;
    #1;
    checkOutput("rst_pc", pcOut, 0);
    checkOutput("rst_A", regA, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_req", dmemReq, 0);

    for (int v = 0; v < 16; v++) begin
      clearProg();
      prog[0] = ins(7'h0D, 8'hFF);
      prog[1] = ins(7'h01, vecs[v].a);
      prog[2] = ins(7'h02, vecs[v].b);
      prog[3] = ins(vecs[v].op, vecs[v].lit);
      prog[4] = ins(7'h23, 8'h20);
      prog[5] = ins(7'h21, 8'h10);
      prog[8'h20] = ins(7'h21, 8'h30);
      applyStimulus();
      waitHalt($sformatf("vec%0d", v), 100);
      checkOutput($sformatf("vec%0d_A", v), regA, vecs[v].expA);
      checkOutput($sformatf("vec%0d_B", v), regB, vecs[v].expB);
      checkOutput($sformatf("vec%0d_pc", v), pcOut, vecs[v].expPc);
    end

    clearProg();
    prog[0] = ins(7'h01, 8'h05); prog[1] = ins(7'h0A, 8'hFC);
    applyStimulus();
    repeat (3) @(posedge clk);
    #1 checkOutput("p27_A_cyc3", regA, 8'h05);
    @(posedge clk);
    #1 checkOutput("p27_A_cyc4", regA, 8'h01);
    checkOutput("p27_pc_cyc4", pcOut, 2);
    repeat (2) @(posedge clk);
    #1 checkOutput("p27_halted", halted, 1);
    checkOutput("p27_pc", pcOut, 2);

    clearProg();
    prog[0] = ins(7'h01, 8'h03); prog[1] = ins(7'h0D, 8'h03); prog[2] = ins(7'h21, 8'h05);
    applyStimulus();
    waitHalt("p28a", 50);
    checkOutput("p28a_pc", pcOut, 5);
    prog[1] = ins(7'h0D, 8'h04); prog[3] = ins(7'h23, 8'h40);
    applyStimulus();
    repeat (6) @(posedge clk);
    #1 checkOutput("p28b_pc", pcOut, 3);
    waitHalt("p28b", 50);
    checkOutput("p28b_jlt", pcOut, 8'h40);

    clearProg();
    prog[0] = ins(7'h01, 8'h5A); prog[1] = ins(7'h12, 8'h10);
    prog[2] = ins(7'h01, 8'h00); prog[3] = ins(7'h10, 8'h10);
    logQ.delete();
    respEnable = 1'b1; randLat = 1'b0; fixedLat = 3; checkTxn = 1'b0;
    applyStimulus();
    waitHalt("p29", 100);
    checkOutput("p29_txnCount", logQ.size(), 2);
    if (logQ.size() >= 2) begin
      checkOutput("p29_stCycles", logQ[0].cycles, 4);
      checkOutput("p29_stAddr", logQ[0].addr, 8'h10);
      checkOutput("p29_stWe", logQ[0].we, 1);
      checkOutput("p29_stWdata", logQ[0].wdata, 8'h5A);
      checkOutput("p29_stStable", logQ[0].stable, 1);
      checkOutput("p29_ldWe", logQ[1].we, 0);
    end
    checkOutput("p29_ldA", regA, 8'h5A);
    checkOutput("p29_pc", pcOut, 4);

    clearProg();
    prog[0] = ins(7'h01, 8'h33);
    respEnable = 1'b0; forceAck = 1'b1;
    applyStimulus();
    waitHalt("strayAck", 50);
    checkOutput("strayAck_A", regA, 8'h33);
    checkOutput("strayAck_pc", pcOut, 1);
    forceAck = 1'b0;

    clearProg();
    prog[0] = ins(7'h01, 8'h77); prog[1] = ins(7'h12, 8'h20);
    dmemArr[8'h20] = 8'h00;
    applyStimulus();
    n = 0;
    while (!dmemReq && n < 20) begin @(negedge clk); n++; end
    checkOutput("p31_reqSeen", dmemReq, 1);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("p31_req", dmemReq, 0);
    checkOutput("p31_pc", pcOut, 0);
    checkOutput("p31_A", regA, 0);
    checkOutput("p31_halted", halted, 0);
    checkOutput("p31_we", dmemWe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    respEnable = 1'b1; fixedLat = 0;
    repeat (2) @(posedge clk);
    #1 checkOutput("p31_restartA", regA, 8'h77);
    waitHalt("p31", 50);
    checkOutput("p31_endPc", pcOut, 2);
    checkOutput("p31_mem", dmemArr[8'h20], 8'h77);

    clearProg2();
    prog2[0] = ins(7'h01, 8'h5C); prog2[1] = ins(7'h28, 8'h03); prog2[3] = ins(7'h28, 8'h05);
    prog2[5] = ins(7'h28, 8'h07); prog2[7] = ins(7'h28, 8'h09); prog2[9] = ins(7'h28, 8'h0B);
    reset2();
    waitHalt2("p30a", 50);
    checkOutput("p30a_fault", fault2, 1);
    checkOutput("p30a_pc", pcOut2, 5);
    checkOutput("p30a_A", regA2, 8'h5C);

    clearProg2();
    prog2[0] = ins(7'h28, 8'h05); prog2[1] = ins(7'h28, 8'h07);
    prog2[5] = ins(7'h01, 8'h0A); prog2[6] = ins(7'h29, 8'h00);
    prog2[7] = ins(7'h0A, 8'h01); prog2[8] = ins(7'h29, 8'h00);
    reset2();
    waitHalt2("p30b", 50);
    checkOutput("p30b_fault", fault2, 0);
    checkOutput("p30b_pc", pcOut2, 2);
    checkOutput("p30b_A", regA2, 8'h0B);

    clearProg2();
    prog2[0] = ins(7'h29, 8'h00);
    reset2();
    waitHalt2("retEmpty", 20);
    checkOutput("retEmpty_fault", fault2, 1);
    checkOutput("retEmpty_pc", pcOut2, 0);

    clearProg2();
    prog2[0] = ins(7'h20, 8'h0F); prog2[15] = ins(7'h00, 8'h00);
    reset2();
    repeat (2) @(posedge clk);
    #1 checkOutput("p32_pcF", pcOut2, 4'hF);
    repeat (2) @(posedge clk);
    #1 checkOutput("p32_wrap", pcOut2, 0);
    checkOutput("p32_req2", dmemReq2, 0);

    respEnable = 1'b1; randLat = 1'b1; checkTxn = 1'b1;
    for (int p = 0; p < 30; p++) begin
      clearProg();
      for (int i = 0; i < 256; i++) dmemArr[i] = 8'($urandom);
      for (int i = 0; i < 47; i++) begin
        r = $urandom_range(99, 0);
        if (r < 45) prog[i] = ins(7'($urandom_range(13, 0)), 8'($urandom));
        else if (r < 65) prog[i] = ins(7'(8'h10 + $urandom_range(3, 0)), 8'($urandom_range(15, 0)));
        else if (r < 85) begin
          op = 'h20 + $urandom_range(4, 0);
          t = i + 1 + $urandom_range(6, 0);
          if (t > 47) t = 47;
          prog[i] = ins(7'(op), 8'(t));
        end
        else if (r < 92) prog[i] = ins(7'(unk[$urandom_range(4, 0)]), 8'($urandom));
        else if (r < 95) prog[i] = ins(7'h29, 8'h00);
        else if (r < 97) prog[i] = ins(7'h7F, 8'h00);
        else prog[i] = ins(7'h02, 8'($urandom_range(15, 0)));
      end
      expQ.delete();
      runModel(mA, mB, mPc, mFault, mHalt);
      applyStimulus();
      waitHalt($sformatf("rnd%0d", p), 3000);
      checkOutput($sformatf("rnd%0d_A", p), regA, mA);
      checkOutput($sformatf("rnd%0d_B", p), regB, mB);
      checkOutput($sformatf("rnd%0d_pc", p), pcOut, mPc);
      checkOutput($sformatf("rnd%0d_fault", p), fault, mFault);
      checkOutput($sformatf("rnd%0d_txnLeft", p), expQ.size(), 0);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (dmemArr[i] !== 8'(modelMem[i])) diffs++;
      checkOutput($sformatf("rnd%0d_memDiffs", p), diffs, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no completion, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/multicycle_computer.md
MULTICYCLE_COMPUTER -- requirements
Module: multicycle_computer

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, data path and register width (>=4).
REQ-002 The block SHALL expose parameter PC_W, default 8, program counter width (<=DATA_W).
REQ-003 The block SHALL expose parameter STACK_DEPTH, default 4, number of return-address entries (>=1).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-006 The block SHALL have port imem_addr  output  PC_W  instruction address, equal to pc_out.
REQ-007 The block SHALL have port imem_data  input  7+DATA_W  instruction word, combinational in the same cycle: [DATA_W+6:DATA_W] opcode, [DATA_W-1:0] literal.
REQ-008 The block SHALL have ports dmem_req, dmem_we  output  1 each  data memory request and write strobe.
REQ-009 The block SHALL have ports dmem_addr, dmem_wdata  output  DATA_W each, and dmem_rdata  input  DATA_W.
REQ-010 The block SHALL have port dmem_ack  input  1  data memory completion, sampled on clk.
REQ-011 The block SHALL have ports regA_out, regB_out  output  DATA_W, and pc_out  output  PC_W  architectural state.
REQ-012 The block SHALL have ports halted, fault  output  1 each  core stopped; stopped on stack error.

Function
REQ-013 The FSM SHALL have states FETCH, EXEC, MEM, HALT; FETCH->EXEC every cycle; EXEC->MEM for loads/stores, otherwise EXEC->FETCH or HALT.
REQ-014 FETCH SHALL latch imem_data into an internal instruction register; non-memory instructions SHALL take 2 cycles.
REQ-015 Opcodes SHALL be: 00 NOP; 01 A=lit; 02 B=lit; 03 A=B; 04 B=A; 05 A=A+B; 06 A=A-B; 07 A=A&B; 08 A=A|B; 09 A=A^B; 0A A=A+lit; 0B A=A-lit; 0C CMP A,B; 0D CMP A,lit.
REQ-016 Opcodes SHALL also be: 10 A=M[lit]; 11 A=M[B]; 12 M[lit]=A; 13 M[B]=A; 20 JMP; 21 JEQ; 22 JNE; 23 JLT; 24 JGE; 28 CALL; 29 RET; 7F HALT; any other opcode executes as NOP.
REQ-017 Arithmetic SHALL be modulo 2^DATA_W; flags Z (result==0), N (result MSB), C (ADD carry-out; SUB/CMP C=1 iff A<operand unsigned).
REQ-018 Flags SHALL update only on opcodes 05-0D; logic ops 07-09 SHALL clear C; CMP SHALL not write A.
REQ-019 Jump target SHALL be literal[PC_W-1:0]; JEQ taken iff Z=1, JNE iff Z=0, JLT iff C=1, JGE iff C=0; not taken gives PC+1.
REQ-020 PC+1 SHALL wrap from 2^PC_W-1 to 0.
REQ-021 In MEM, dmem_req SHALL be 1 with dmem_addr, dmem_we, dmem_wdata (=A) held stable until the cycle dmem_ack=1; that edge SHALL load A from dmem_rdata (loads), set PC+1, go FETCH.
REQ-022 dmem_req SHALL be 0 in every state but MEM; dmem_ack outside MEM SHALL be ignored.
REQ-023 CALL SHALL push PC+1 and jump; RET SHALL pop into PC; push with STACK_DEPTH entries held, or pop when empty, SHALL set fault=1 and enter HALT with PC, A, B, and the stack unchanged.
REQ-024 HALT opcode SHALL enter HALT with PC unchanged; HALT SHALL be left only by reset; halted=1 iff state is HALT.

Reset
REQ-025 rst_n=0 SHALL immediately force state FETCH, PC=0, A=0, B=0, flags=0, stack empty, fault=0, halted=0, and dmem_req=0, including when it is asserted during MEM.
REQ-026 First instruction fetch SHALL occur at address 0 on the first rising edge after rst_n deasserts.

Verification
REQ-027 Program 01 05; 0A FC; 7F (DATA_W=8) -> A=0x01, Z=0, C=1 after 4 cycles; halted=1 with pc_out=2.
REQ-028 Program 01 03; 0D 03; 21 05 at addr 2 -> JEQ taken, pc_out=5 at FETCH; with CMP literal 04 -> pc_out=3, C=1.
REQ-029 ST M[0x10]=A=0x5A with dmem_ack delayed 3 cycles -> dmem_req high exactly 4 cycles, addr 0x10, we=1, wdata 0x5A stable throughout; then LD A,M[0x10] returns 0x5A.
REQ-030 STACK_DEPTH=2, five nested CALLs -> third CALL sets fault=1, halted=1, pc_out equals that CALL's address; two matched CALL/RET pairs return to call-site+1.
REQ-031 rst_n pulsed low during MEM -> dmem_req falls before next clk edge; all outputs at reset values; execution restarts at address 0.
REQ-032 PC_W=4, JMP 0F then NOP -> pc_out wraps 15->0.
